// File: rtl/detector_limiar_persistente_if.sv
// Sample/result bundle between a comparator-side driver and the persistence filter.
// The driver (master) presents strobed comparator outputs; the filter (slave) returns registered status.
interface detector_limiar_persistente_if #(
    parameter int C = 8
);
    logic         limpa;
    logic         habilita;
    logic         amostra_valida;
    logic         alb;
    logic         agb;
    logic         aeb;
    logic         alarme;
    logic         pulso_alarme;
    logic [C-1:0] eventos;
    logic         erro;
    logic [1:0]   estado;

    modport master (
        output limpa, habilita, amostra_valida, alb, agb, aeb,
        input  alarme, pulso_alarme, eventos, erro, estado
    );

    modport slave (
        input  limpa, habilita, amostra_valida, alb, agb, aeb,
        output alarme, pulso_alarme, eventos, erro, estado
    );
endinterface

// File: rtl/detector_limiar_persistente.sv
// Persistence filter: raises an alarm after K consecutive "above" samples and releases it after
// R consecutive "not above" samples; counts raised alarms and flags malformed comparator words.
module detector_limiar_persistente #(
    parameter int K            = 4,
    parameter int R            = 4,
    parameter int INCLUI_IGUAL = 0,
    parameter int C            = 8
) (
    input  logic                         clock,
    input  logic                         reset_n,
    detector_limiar_persistente_if.slave bus
);
    localparam int             MAX_KR = (K > R) ? K : R;
    localparam int             CW     = $clog2(MAX_KR + 1);
    localparam logic [CW-1:0]  CNT_UM = CW'(1);
    localparam logic [CW-1:0]  K_W    = CW'(K);
    localparam logic [CW-1:0]  R_W    = CW'(R);
    localparam logic [C-1:0]   EV_MAX = '1;
    localparam logic [C-1:0]   EV_UM  = C'(1);
    localparam logic           IGUAL  = (INCLUI_IGUAL != 0);

    typedef enum logic [1:0] {
        NORMAL    = 2'b00,
        SUSPEITA  = 2'b01,
        ALARME    = 2'b10,
        LIBERANDO = 2'b11
    } estado_t;

    estado_t       r_estado, w_prox_estado;
    logic [CW-1:0] r_cnt, w_prox_cnt, w_cnt_mais;
    logic          w_aceita, w_one_hot, w_acima, w_sobe;
    logic          r_pulso, w_prox_pulso;
    logic          r_erro, w_prox_erro;
    logic [C-1:0]  r_eventos, w_prox_eventos;

    assign w_aceita   = bus.amostra_valida & bus.habilita & ~bus.limpa;
    assign w_one_hot  = $onehot({bus.alb, bus.agb, bus.aeb});
    assign w_acima    = bus.agb | (IGUAL & bus.aeb);
    assign w_cnt_mais = r_cnt + CNT_UM;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_estado <= NORMAL;
            r_cnt    <= '0;
        end else begin
            r_estado <= w_prox_estado;
            r_cnt    <= w_prox_cnt;
        end
    end

    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    always_comb begin
        w_prox_estado = r_estado;
        w_prox_cnt    = r_cnt;
        w_sobe        = 1'b0;
        if (bus.limpa) begin
            w_prox_estado = NORMAL;
            w_prox_cnt    = '0;
        end else if (w_aceita && w_one_hot) begin
            unique case (r_estado)
                NORMAL: begin
                    if (w_acima) begin
                        if (K == 1) begin
                            w_prox_estado = ALARME;
                            w_sobe        = 1'b1;
                        end else begin
                            w_prox_estado = SUSPEITA;
                            w_prox_cnt    = CNT_UM;
                        end
                    end
                end
                SUSPEITA: begin
                    if (!w_acima) begin
                        w_prox_estado = NORMAL;
                        w_prox_cnt    = '0;
                    end else if (w_cnt_mais == K_W) begin
                        w_prox_estado = ALARME;
                        w_prox_cnt    = '0;
                        w_sobe        = 1'b1;
                    end else begin
                        w_prox_cnt = w_cnt_mais;
                    end
                end
                ALARME: begin
                    if (!w_acima) begin
                        if (R == 1) begin
                            w_prox_estado = NORMAL;
                        end else begin
                            w_prox_estado = LIBERANDO;
                            w_prox_cnt    = CNT_UM;
                        end
                    end
                end
                LIBERANDO: begin
                    // Returning to ALARME is a continuation of the same event, not a new one.
                    if (w_acima) begin
                        w_prox_estado = ALARME;
                        w_prox_cnt    = '0;
                    end else if (w_cnt_mais == R_W) begin
                        w_prox_estado = NORMAL;
                        w_prox_cnt    = '0;
                    end else begin
                        w_prox_cnt = w_cnt_mais;
                    end
                end
                default: begin
                    w_prox_estado = NORMAL;
                    w_prox_cnt    = '0;
                end
            endcase
        end
    end

    always_comb begin
        w_prox_pulso   = w_sobe;
        w_prox_erro    = r_erro;
        w_prox_eventos = r_eventos;
        if (bus.limpa) begin
            w_prox_erro    = 1'b0;
            w_prox_eventos = '0;
        end else begin
            if (w_aceita && !w_one_hot) w_prox_erro = 1'b1;
            if (w_sobe && (r_eventos != EV_MAX)) w_prox_eventos = r_eventos + EV_UM;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_pulso   <= 1'b0;
            r_erro    <= 1'b0;
            r_eventos <= '0;
        end else begin
            r_pulso   <= w_prox_pulso;
            r_erro    <= w_prox_erro;
            r_eventos <= w_prox_eventos;
        end
    end

    assign bus.alarme       = r_estado[1];
    assign bus.estado       = r_estado;
    assign bus.pulso_alarme = r_pulso;
    assign bus.erro         = r_erro;
    assign bus.eventos      = r_eventos;
endmodule

// File: tb/tb_detector_limiar_persistente.sv
// Bench for the persistence filter: three parameterisations share one stimulus stream, each checked
// every cycle against an independent run-length model through a scoreboard queue.
module tb_detector_limiar_persistente;
    localparam int PK [3] = '{4, 2, 4};
    localparam int PR [3] = '{4, 4, 4};
    localparam int PI [3] = '{0, 1, 0};
    localparam int PC [3] = '{8, 8, 2};
    localparam bit [2:0] ALB = 3'b100, AGB = 3'b010, AEB = 3'b001;

    typedef struct {
        bit alarm;
        int above;
        int below;
        int ev;
        bit erro;
        bit pulso;
    } mdl_t;

    typedef struct {
        int         idx;
        logic       alarme;
        logic       pulso;
        int         eventos;
        logic       erro;
        logic [1:0] estado;
    } exp_t;

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    logic s_limpa = 0, s_hab = 0, s_valid = 0, s_alb = 0, s_agb = 0, s_aeb = 0;

    int   n_tests = 0;
    int   n_fail  = 0;
    int   n_ciclo = 0;
    mdl_t m [3];
    exp_t sb [$];

    always #5 clock = ~clock;

    detector_limiar_persistente_if #(.C(8)) if0 ();
    detector_limiar_persistente_if #(.C(8)) if1 ();
    detector_limiar_persistente_if #(.C(2)) if2 ();

    assign if0.limpa = s_limpa;  assign if0.habilita = s_hab;  assign if0.amostra_valida = s_valid;
    assign if0.alb = s_alb;      assign if0.agb = s_agb;       assign if0.aeb = s_aeb;
    assign if1.limpa = s_limpa;  assign if1.habilita = s_hab;  assign if1.amostra_valida = s_valid;
    assign if1.alb = s_alb;      assign if1.agb = s_agb;       assign if1.aeb = s_aeb;
    assign if2.limpa = s_limpa;  assign if2.habilita = s_hab;  assign if2.amostra_valida = s_valid;
    assign if2.alb = s_alb;      assign if2.agb = s_agb;       assign if2.aeb = s_aeb;

    detector_limiar_persistente #(.K(4), .R(4), .INCLUI_IGUAL(0), .C(8)) u0 (
        .clock(clock), .reset_n(reset_n), .bus(if0));
    detector_limiar_persistente #(.K(2), .R(4), .INCLUI_IGUAL(1), .C(8)) u1 (
        .clock(clock), .reset_n(reset_n), .bus(if1));
    detector_limiar_persistente #(.K(4), .R(4), .INCLUI_IGUAL(0), .C(2)) u2 (
        .clock(clock), .reset_n(reset_n), .bus(if2));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Run-length view of the filter: count consecutive above / not-above samples.
    function automatic mdl_t model_step(mdl_t s, int i, bit v, bit hab, bit lim, bit [2:0] lga);
        mdl_t n;
        bit   acima;
        n       = s;
        n.pulso = 1'b0;
        if (lim) begin
            n = '{default: 0};
        end else if (v && hab) begin
            if (!(lga == ALB || lga == AGB || lga == AEB)) begin
                n.erro = 1'b1;
            end else begin
                acima = lga[1] || (PI[i] != 0 && lga[0]);
                if (!n.alarm) begin
                    if (acima) begin
                        n.above++;
                        if (n.above == PK[i]) begin
                            n.alarm = 1'b1;
                            n.above = 0;
                            n.pulso = 1'b1;
                            if (n.ev < (1 << PC[i]) - 1) n.ev++;
                        end
                    end else begin
                        n.above = 0;
                    end
                end else if (acima) begin
                    n.below = 0;
                end else begin
                    n.below++;
                    if (n.below == PR[i]) begin
                        n.alarm = 1'b0;
                        n.below = 0;
                    end
                end
            end
        end
        return n;
    endfunction

    function automatic exp_t expect_of(mdl_t s, int i);
        exp_t e;
        e.idx     = i;
        e.alarme  = s.alarm;
        e.pulso   = s.pulso;
        e.eventos = s.ev;
        e.erro    = s.erro;
        e.estado  = s.alarm ? ((s.below != 0) ? 2'b11 : 2'b10) : ((s.above != 0) ? 2'b01 : 2'b00);
        return e;
    endfunction

    function automatic exp_t obs(int i);
        exp_t o;
        o.idx = i;
        case (i)
            0: begin o.alarme = if0.alarme; o.pulso = if0.pulso_alarme; o.eventos = int'(if0.eventos);
                     o.erro = if0.erro; o.estado = if0.estado; end
            1: begin o.alarme = if1.alarme; o.pulso = if1.pulso_alarme; o.eventos = int'(if1.eventos);
                     o.erro = if1.erro; o.estado = if1.estado; end
            default: begin o.alarme = if2.alarme; o.pulso = if2.pulso_alarme; o.eventos = int'(if2.eventos);
                     o.erro = if2.erro; o.estado = if2.estado; end
        endcase
        return o;
    endfunction

    // Called at a falling edge; returns at the next falling edge after comparing all instances.
    task automatic ciclo(input bit v, input bit hab, input bit lim, input bit [2:0] lga);
        exp_t e, o;
        s_valid = v; s_hab = hab; s_limpa = lim;
        {s_alb, s_agb, s_aeb} = lga;
        @(posedge clock);
        for (int i = 0; i < 3; i++) begin
            m[i] = model_step(m[i], i, v, hab, lim, lga);
            sb.push_back(expect_of(m[i], i));
        end
        @(negedge clock);
        n_ciclo++;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            o = obs(e.idx);
            check($sformatf("c%0d_u%0d_alarme", n_ciclo, e.idx), 32'(o.alarme), 32'(e.alarme));
            check($sformatf("c%0d_u%0d_pulso", n_ciclo, e.idx), 32'(o.pulso), 32'(e.pulso));
            check($sformatf("c%0d_u%0d_eventos", n_ciclo, e.idx), o.eventos, e.eventos);
            check($sformatf("c%0d_u%0d_erro", n_ciclo, e.idx), 32'(o.erro), 32'(e.erro));
            check($sformatf("c%0d_u%0d_estado", n_ciclo, e.idx), 32'(o.estado), 32'(e.estado));
        end
        s_valid = 1'b0;
    endtask

    task automatic amostra(input bit [2:0] lga);
        ciclo(1'b1, 1'b1, 1'b0, lga);
    endtask

    task automatic ocioso();
        ciclo(1'b0, 1'b1, 1'b0, 3'b000);
    endtask

    task automatic check_zerado(input string tag);
        for (int i = 0; i < 3; i++) begin
            exp_t o;
            o = obs(i);
            check($sformatf("%s_u%0d", tag, i),
                  {27'd0, o.alarme, o.pulso, o.erro, o.estado} | 32'(o.eventos), 32'd0);
        end
    endtask

    initial begin
        for (int i = 0; i < 3; i++) m[i] = '{default: 0};
        @(negedge clock);
        check_zerado("reset_inicial");
        reset_n = 1'b1;

        // Four above samples separated by idle cycles: alarm one cycle after the 4th strobe.
        for (int j = 0; j < 4; j++) begin
            amostra(AGB);
            if (j < 3) ocioso();
        end
        check("t1_alarme", 32'(if0.alarme), 32'd1);
        check("t1_pulso", 32'(if0.pulso_alarme), 32'd1);
        ocioso();
        check("t1_pulso_baixo", 32'(if0.pulso_alarme), 32'd0);
        check("t1_eventos", 32'(if0.eventos), 32'd1);

        // Release, then an interrupted run of above samples must not alarm.
        for (int j = 0; j < 4; j++) amostra(ALB);
        amostra(AGB); amostra(AGB); amostra(AGB); amostra(ALB);
        amostra(AGB); amostra(AGB); amostra(AGB);
        check("t2_alarme", 32'(if0.alarme), 32'd0);
        check("t2_estado", 32'(if0.estado), 32'd1);
        check("t2_eventos", 32'(if0.eventos), 32'd1);

        // Interrupted release keeps the alarm without counting a second event.
        amostra(AGB);
        check("t3_eventos_sobe", 32'(if0.eventos), 32'd2);
        for (int j = 0; j < 3; j++) amostra(ALB);
        check("t3_liberando", 32'(if0.estado), 32'd3);
        amostra(AGB);
        check("t3_volta_alarme", 32'(if0.estado), 32'd2);
        check("t3_sem_pulso", 32'(if0.pulso_alarme), 32'd0);
        for (int j = 0; j < 3; j++) amostra(ALB);
        check("t3_ainda_alarme", 32'(if0.alarme), 32'd1);
        amostra(ALB);
        check("t3_liberado", 32'(if0.alarme), 32'd0);
        check("t3_eventos", 32'(if0.eventos), 32'd2);

        // Equality counts as above on u1; malformed words flag erro only when enabled.
        amostra(AEB); amostra(AEB);
        check("t4_alarme_igual", 32'(if1.alarme), 32'd1);
        check("t4_u0_ignora_igual", 32'(if0.estado), 32'd0);
        ciclo(1'b1, 1'b0, 1'b0, 3'b110);
        check("t4_erro_desabilitado", 32'(if1.erro), 32'd0);
        ciclo(1'b1, 1'b0, 1'b0, ALB);
        check("t4_congelado", 32'(if1.estado), 32'd2);
        amostra(3'b110);
        check("t4_erro", 32'(if1.erro), 32'd1);
        check("t4_estado_mantido", 32'(if1.estado), 32'd2);
        amostra(3'b000);
        check("t4_erro_pegajoso", 32'(if1.erro), 32'd1);
        ciclo(1'b1, 1'b1, 1'b1, AGB);
        check("t4_limpa_erro", 32'(if1.erro), 32'd0);
        check("t4_limpa_eventos", 32'(if1.eventos), 32'd0);
        check("t4_limpa_estado", 32'(if1.estado), 32'd0);
        check("t4_limpa_u0_estado", 32'(if0.estado), 32'd0);

        // Five back-to-back raise/release rounds: the 2-bit counter saturates at 3.
        for (int r = 0; r < 5; r++) begin
            for (int j = 0; j < 4; j++) amostra(AGB);
            for (int j = 0; j < 4; j++) amostra(ALB);
        end
        check("t5_saturado", 32'(if2.eventos), 32'd3);
        check("t5_u0_eventos", 32'(if0.eventos), 32'd5);

        // Asynchronous reset while in SUSPEITA discards progress immediately.
        amostra(AGB); amostra(AGB); amostra(AGB);
        check("t6_suspeita", 32'(if0.estado), 32'd1);
        #2 reset_n = 1'b0;
        #1 check_zerado("reset_assincrono");
        for (int i = 0; i < 3; i++) m[i] = '{default: 0};
        @(negedge clock);
        reset_n = 1'b1;
        amostra(AGB); amostra(AGB); amostra(AGB);
        check("t6_sem_alarme", 32'(if0.alarme), 32'd0);
        amostra(AGB);
        check("t6_alarme_novo", 32'(if0.alarme), 32'd1);
        ocioso();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/detector_limiar_persistente.md
# detector_limiar_persistente

Sequential persistence filter directly downstream of `comparador_85_n`. Consumes the cascade outputs (A<B, A>B, A=B) on a per-sample strobe. Asserts a registered alarm only after K consecutive "above threshold" samples and releases it only after R consecutive "not above" samples, which suppresses chatter around the threshold. Also counts alarm events and flags malformed comparator outputs.

## Interface
- `K`, 4, consecutive above-samples required to raise alarm (≥1)
- `R`, 4, consecutive not-above samples required to release alarm (≥1)
- `INCLUI_IGUAL`, 0, 1 = A=B counts as "above"
- `C`, 8, width of event counter
- `clock`  in  1  system clock, rising edge
- `reset_n`  in  1  asynchronous, active-low reset
- `limpa`  in  1  synchronous clear, active-high
- `habilita`  in  1  1 = samples processed; 0 = samples ignored, state held
- `amostra_valida`  in  1  one-cycle strobe; comparator outputs are valid this cycle
- `alb`  in  1  A<B from comparator
- `agb`  in  1  A>B from comparator
- `aeb`  in  1  A=B from comparator
- `alarme`  out  1  registered alarm level
- `pulso_alarme`  out  1  one-cycle pulse when a new alarm is raised
- `eventos`  out  C  count of raised alarms, saturating
- `erro`  out  1  sticky: a sample arrived with non-one-hot {alb,agb,aeb}
- `estado`  out  2  debug state code

## Operation
- Sample accepted when `amostra_valida & habilita & ~limpa`.
- Accepted sample whose {alb,agb,aeb} is not exactly one-hot: sets `erro`. FSM, counter and outputs are unchanged, so the sample is ignored.
- acima = `agb | (INCLUI_IGUAL & aeb)`.
- Internal counter `cnt` is wide enough for max(K,R).
- States, with encodings:
  - NORMAL (00): acima → if K==1 go to ALARME; else cnt=1, go to SUSPEITA. Not acima → stay.
  - SUSPEITA (01): acima → if cnt+1==K go to ALARME, cnt=0; else cnt++. Not acima → NORMAL, cnt=0.
  - ALARME (10): acima → stay. Not acima → if R==1 go to NORMAL; else cnt=1, go to LIBERANDO.
  - LIBERANDO (11): not acima → if cnt+1==R go to NORMAL, cnt=0; else cnt++. Acima → ALARME, cnt=0. No new event is counted.
- `alarme` = 1 in ALARME and LIBERANDO.
- `pulso_alarme` fires only on transitions NORMAL→ALARME or SUSPEITA→ALARME. On that same edge `eventos` increments, saturating at 2^C−1.
- `limpa` forces NORMAL, cnt=0, `eventos`=0, `erro`=0, `pulso_alarme`=0. It has priority over a simultaneous sample.
- `habilita`=0 freezes everything. `erro` still holds its value, and malformed samples are not flagged while disabled.

## Timing
- All outputs are registered; there is no combinational path from inputs to outputs.
- `reset_n` low, asynchronously: state NORMAL, cnt=0, `alarme`=0, `pulso_alarme`=0, `eventos`=0, `erro`=0, `estado`=00.
- Latency: if the Kth consecutive acima sample is strobed in cycle n, `alarme` and `pulso_alarme` are high in cycle n+1. `pulso_alarme` is low again in cycle n+2.
- Release: `alarme` falls in the cycle after the Rth consecutive not-acima sample.
- Non-strobe cycles between samples do not break consecutiveness.
- Reset asserted mid-sequence (e.g. in SUSPEITA with cnt=K−1) discards progress. After release, K fresh samples are required.
- Back-to-back strobes (every cycle) are supported.

## Test plan
- Defaults; strobe agb=1 four times, one idle cycle between strobes → `alarme`=1 and one `pulso_alarme` exactly one cycle after the 4th strobe; `eventos`=1.
- Defaults; pattern agb,agb,agb,alb,agb,agb,agb → `alarme` stays 0, `estado` ends at 01 with no event counted.
- From ALARME: alb ×3, then agb, then alb ×4 → `alarme` stays 1 through the interrupted release, drops after the 4th alb, no second pulse, `eventos` unchanged.
- INCLUI_IGUAL=1, K=2: aeb,aeb → alarm raised. Then sample {alb,agb,aeb}=110 → `erro`=1 and the state is unchanged. Then `limpa` → `erro`=0, `eventos`=0, `estado`=00.
- C=2: raise and release the alarm 5 times → `eventos` saturates at 3. Also pulse `reset_n` low while in SUSPEITA → all outputs are 0 immediately, without waiting for a clock edge.
